// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encoding,
// default widths and a small occupancy helper.
package pipe_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int NUM_OPS_DEF = 4;
   localparam int REG_AW_DEF  = 5;
   localparam int CTRL_W_DEF  = 10;
   localparam int SEQ_W_DEF   = 8;
   localparam int CNT_W_DEF   = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_st_e;

   // The encoding is chosen so that the state value equals the entry count.
   function automatic logic [1:0] occ_of(input stage_st_e st);
      return logic'(st == ST_FULL) ? 2'd2 : (st == ST_ONE) ? 2'd1 : 2'd0;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int WIDTH = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && !(&count_q)) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with a main register and one skid register, so in_ready can
// be registered while still sustaining one entry per cycle.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | nothing held, outputs show a bubble
// ST_ONE   | main register valid, skid free
// ST_FULL  | main and skid valid, upstream stalled
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int NUM_OPS = NUM_OPS_DEF,
   parameter int REG_AW  = REG_AW_DEF,
   parameter int CTRL_W  = CTRL_W_DEF,
   parameter int SEQ_W   = SEQ_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_OPS*DATA_W-1:0] in_ops,
   input  logic [3*REG_AW-1:0]       in_addr,
   input  logic [CTRL_W-1:0]         in_ctrl,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_OPS*DATA_W-1:0] out_ops,
   output logic [3*REG_AW-1:0]       out_addr,
   output logic [CTRL_W-1:0]         out_ctrl,
   output logic [SEQ_W-1:0]          out_seq,
   output logic [1:0]                occupancy,
   output logic [CNT_W-1:0]          bubble_cnt
);

   localparam int OPS_W  = NUM_OPS * DATA_W;
   localparam int ADDR_W = 3 * REG_AW;

   stage_st_e state_q, state_d;
   logic      in_ready_q, in_ready_d;

   logic [OPS_W-1:0]  main_ops_q,  main_ops_d;
   logic [ADDR_W-1:0] main_addr_q, main_addr_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [SEQ_W-1:0]  main_seq_q,  main_seq_d;

   logic [OPS_W-1:0]  skid_ops_q,  skid_ops_d;
   logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [SEQ_W-1:0]  skid_seq_q,  skid_seq_d;

   logic [SEQ_W-1:0]  seq_q, seq_d;

   logic accept;
   logic deliver;
   logic load_main_in;
   logic load_skid;
   logic skid_to_main;
   logic bubble;

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid & in_ready_q;
   assign deliver   = out_valid & out_ready;
   assign bubble    = ~out_valid & out_ready;

   always_comb begin
      state_d      = state_q;
      load_main_in = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d      = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && deliver) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_d   = ST_FULL;
                  load_skid = 1'b1;
               end else if (deliver) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (deliver) begin
                  state_d      = ST_ONE;
                  skid_to_main = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      // Registered ready looks at the next state, so it never depends on out_ready this cycle.
      in_ready_d = (state_d != ST_FULL);
   end

   always_comb begin
      main_ops_d  = main_ops_q;
      main_addr_d = main_addr_q;
      main_ctrl_d = main_ctrl_q;
      main_seq_d  = main_seq_q;
      if (load_main_in) begin
         main_ops_d  = in_ops;
         main_addr_d = in_addr;
         main_ctrl_d = in_ctrl;
         main_seq_d  = seq_q;
      end else if (skid_to_main) begin
         main_ops_d  = skid_ops_q;
         main_addr_d = skid_addr_q;
         main_ctrl_d = skid_ctrl_q;
         main_seq_d  = skid_seq_q;
      end
   end

   always_comb begin
      skid_ops_d  = skid_ops_q;
      skid_addr_d = skid_addr_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_seq_d  = skid_seq_q;
      if (load_skid) begin
         skid_ops_d  = in_ops;
         skid_addr_d = in_addr;
         skid_ctrl_d = in_ctrl;
         skid_seq_d  = seq_q;
      end
   end

   // A flushed same-cycle accept never consumes a tag.
   always_comb begin
      seq_d = seq_q;
      if (accept && !flush) begin
         seq_d = seq_q + {{(SEQ_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_ops_q  <= '0;
         main_addr_q <= '0;
         main_ctrl_q <= '0;
         main_seq_q  <= '0;
      end else begin
         main_ops_q  <= main_ops_d;
         main_addr_q <= main_addr_d;
         main_ctrl_q <= main_ctrl_d;
         main_seq_q  <= main_seq_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skid_ops_q  <= '0;
         skid_addr_q <= '0;
         skid_ctrl_q <= '0;
         skid_seq_q  <= '0;
      end else begin
         skid_ops_q  <= skid_ops_d;
         skid_addr_q <= skid_addr_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_seq_q  <= skid_seq_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seq_q <= '0;
      end else begin
         seq_q <= seq_d;
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (bubble),
      .clear (1'b0),
      .count (bubble_cnt)
   );

   assign in_ready  = in_ready_q;
   assign out_ops   = main_ops_q;
   assign out_addr  = main_addr_q;
   assign out_ctrl  = out_valid ? main_ctrl_q : '0;
   assign out_seq   = main_seq_q;
   assign occupancy = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: ordering, backpressure, flush, tag wrap,
// bubble saturation and asynchronous reset.
module tb_pipe_stage_skid;

   localparam int DATA_W  = 32;
   localparam int NUM_OPS = 4;
   localparam int REG_AW  = 5;
   localparam int CTRL_W  = 10;
   localparam int SEQ_W   = 8;
   localparam int CNT_W   = 4;

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic                      in_valid = 1'b0;
   logic                      in_ready;
   logic [NUM_OPS*DATA_W-1:0] in_ops = '0;
   logic [3*REG_AW-1:0]       in_addr = '0;
   logic [CTRL_W-1:0]         in_ctrl = '0;
   logic                      flush = 1'b0;
   logic                      out_valid;
   logic                      out_ready = 1'b0;
   logic [NUM_OPS*DATA_W-1:0] out_ops;
   logic [3*REG_AW-1:0]       out_addr;
   logic [CTRL_W-1:0]         out_ctrl;
   logic [SEQ_W-1:0]          out_seq;
   logic [1:0]                occupancy;
   logic [CNT_W-1:0]          bubble_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(
      .DATA_W  (DATA_W),
      .NUM_OPS (NUM_OPS),
      .REG_AW  (REG_AW),
      .CTRL_W  (CTRL_W),
      .SEQ_W   (SEQ_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ops     (in_ops),
      .in_addr    (in_addr),
      .in_ctrl    (in_ctrl),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ops    (out_ops),
      .out_addr   (out_addr),
      .out_ctrl   (out_ctrl),
      .out_seq    (out_seq),
      .occupancy  (occupancy),
      .bubble_cnt (bubble_cnt)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [CTRL_W-1:0] ctrl_of(input logic [31:0] w0);
      return w0[CTRL_W-1:0] | 10'h001;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] w0);
      in_valid = v;
      in_ops   = {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
      in_addr  = w0[3*REG_AW-1:0];
      in_ctrl  = ctrl_of(w0);
   endtask

   task automatic expect_entry(input string tag, input logic [31:0] w0, input logic [7:0] seq);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_w0"}, 64'(out_ops[31:0]), 64'(w0));
      check({tag, "_w3"}, 64'(out_ops[127:96]), 64'(w0 + 32'd3));
      check({tag, "_addr"}, 64'(out_addr), 64'(w0[3*REG_AW-1:0]));
      check({tag, "_ctrl"}, 64'(out_ctrl), 64'(ctrl_of(w0)));
      check({tag, "_seq"}, 64'(out_seq), 64'(seq));
   endtask

   // Entered and left just after a rising edge; release lands mid-cycle.
   task automatic do_reset();
      drive(1'b0, 32'h0);
      flush     = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b0;
      #12;
      reset = 1'b1;
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      // reset values
      #2;
      reset = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready0", 64'(in_ready), 64'd0);
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_ops", 64'(out_ops[63:0]), 64'd0);
      check("rst_seq", 64'(out_seq), 64'd0);
      check("rst_bubble", 64'(bubble_cnt), 64'd0);
      #9;
      reset = 1'b1;
      tick();
      check("rel_in_ready", 64'(in_ready), 64'd1);

      // bubble counter, saturating at 15 with CNT_W=4
      out_ready = 1'b1;
      repeat (3) tick();
      check("bubble_3", 64'(bubble_cnt), 64'd3);
      repeat (12) tick();
      check("bubble_15", 64'(bubble_cnt), 64'd15);
      repeat (6) tick();
      check("bubble_sat", 64'(bubble_cnt), 64'd15);

      // single entry, one-cycle latency
      do_reset();
      out_ready = 1'b1;
      drive(1'b1, 32'h1111_1111);
      tick();
      expect_entry("single", 32'h1111_1111, 8'd0);
      check("single_occ", 64'(occupancy), 64'd1);
      drive(1'b0, 32'h0);
      tick();
      check("single_drain_valid", 64'(out_valid), 64'd0);
      check("single_drain_ctrl", 64'(out_ctrl), 64'd0);
      check("single_drain_occ", 64'(occupancy), 64'd0);

      // backpressure: A,B fill the stage, C is held off
      do_reset();
      drive(1'b1, 32'hA000_0000);
      tick();
      check("bp_occ1", 64'(occupancy), 64'd1);
      check("bp_rdy1", 64'(in_ready), 64'd1);
      drive(1'b1, 32'hB000_0000);
      tick();
      check("bp_occ2", 64'(occupancy), 64'd2);
      check("bp_rdy2", 64'(in_ready), 64'd0);
      expect_entry("bp_holdA", 32'hA000_0000, 8'd0);
      drive(1'b1, 32'hC000_0000);
      tick();
      check("bp_occ_stall", 64'(occupancy), 64'd2);
      check("bp_stall_w0", 64'(out_ops[31:0]), 64'hA000_0000);
      out_ready = 1'b1;
      tick();
      expect_entry("bp_B", 32'hB000_0000, 8'd1);
      check("bp_rdy_after", 64'(in_ready), 64'd1);
      tick();
      expect_entry("bp_C", 32'hC000_0000, 8'd2);
      drive(1'b0, 32'h0);
      tick();
      check("bp_empty", 64'(out_valid), 64'd0);

      // flush while FULL, then while ONE with a live accept
      do_reset();
      drive(1'b1, 32'h0A0A_0000);
      tick();
      drive(1'b1, 32'h0B0B_0000);
      tick();
      check("fl_full", 64'(occupancy), 64'd2);
      drive(1'b1, 32'h0D0D_0000);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_valid", 64'(out_valid), 64'd0);
      check("fl_ctrl", 64'(out_ctrl), 64'd0);
      check("fl_occ", 64'(occupancy), 64'd0);
      drive(1'b1, 32'h0E0E_0000);
      tick();
      expect_entry("fl_next", 32'h0E0E_0000, 8'd2);
      drive(1'b1, 32'h0F0F_0000);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl1_occ", 64'(occupancy), 64'd0);
      drive(1'b1, 32'h0606_0000);
      tick();
      expect_entry("fl1_next", 32'h0606_0000, 8'd3);
      drive(1'b0, 32'h0);
      out_ready = 1'b1;
      tick();

      // tag wrap over 257 streaming accepts
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 255; i++) begin
         drive(1'b1, 32'h5000_0000 + 32'(i));
         tick();
         check("wrap_run", 64'(out_seq), 64'(i));
      end
      check("wrap_254", 64'(out_seq), 64'd254);
      drive(1'b1, 32'h6000_0000);
      tick();
      expect_entry("wrap_255", 32'h6000_0000, 8'd255);
      drive(1'b1, 32'h7000_0000);
      tick();
      expect_entry("wrap_0", 32'h7000_0000, 8'd0);
      drive(1'b0, 32'h0);
      tick();

      // asynchronous reset while FULL
      do_reset();
      drive(1'b1, 32'h1234_0000);
      tick();
      drive(1'b1, 32'h5678_0000);
      tick();
      check("ar_full", 64'(occupancy), 64'd2);
      drive(1'b1, 32'h9ABC_0000);
      #3;
      reset = 1'b0;
      #1;
      check("ar_valid", 64'(out_valid), 64'd0);
      check("ar_occ", 64'(occupancy), 64'd0);
      check("ar_rdy", 64'(in_ready), 64'd0);
      check("ar_ops", 64'(out_ops[63:0]), 64'd0);
      check("ar_ctrl", 64'(out_ctrl), 64'd0);
      check("ar_seq", 64'(out_seq), 64'd0);
      #3;
      reset = 1'b1;
      tick();
      check("ar_rdy_rel", 64'(in_ready), 64'd1);
      check("ar_noacc", 64'(out_valid), 64'd0);
      tick();
      expect_entry("ar_resume", 32'h9ABC_0000, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of each operand word.
REQ-002 Parameter NUM_OPS, default 4, number of operand words carried (rs, rt, sign-extended immediate, instruction).
REQ-003 Parameter REG_AW, default 5, width of each register address; three addresses (rs, rt, rd) carried.
REQ-004 Parameter CTRL_W, default 10, width of the packed control bundle.
REQ-005 Parameter SEQ_W, default 8, width of the sequence tag.
REQ-006 Parameter CNT_W, default 16, width of the bubble counter.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 in_valid  input  1  upstream stage presents an entry.
REQ-010 in_ready  output  1  stage accepts an entry this cycle.
REQ-011 in_ops  input  NUM_OPS*DATA_W  operand words, word 0 in LSBs.
REQ-012 in_addr  input  3*REG_AW  {rd, rt, rs}, rs in LSBs.
REQ-013 in_ctrl  input  CTRL_W  packed control bundle.
REQ-014 flush  input  1  kill all held entries (branch/jump redirect).
REQ-015 out_valid  output  1  downstream entry present.
REQ-016 out_ready  input  1  downstream accepts entry.
REQ-017 out_ops, out_addr, out_ctrl  output  same widths as inputs  held entry.
REQ-018 out_seq  output  SEQ_W  tag of held entry.
REQ-019 occupancy  output  2  entries held (0..2).
REQ-020 bubble_cnt  output  CNT_W  saturating count of bubbles delivered.

Function
REQ-021 Storage SHALL be a main register plus one skid register; state machine EMPTY, ONE, FULL; occupancy = 0/1/2 respectively.
REQ-022 in_ready SHALL be registered and equal 1 iff state != FULL; no combinational path from out_ready to in_ready.
REQ-023 Accept = in_valid & in_ready; deliver = out_valid & out_ready; out_valid = (state != EMPTY).
REQ-024 Outputs SHALL always reflect the main register; latency input to output is exactly one cycle when the stage is EMPTY.
REQ-025 EMPTY: accept -> ONE (load main).
REQ-026 ONE: accept & deliver -> ONE (load main); accept & !deliver -> FULL (load skid); deliver only -> EMPTY; neither -> ONE.
REQ-027 FULL: deliver -> ONE (skid moves to main); otherwise hold; no accept possible.
REQ-028 Entries SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-029 Each accepted entry SHALL be tagged with a free-running SEQ_W counter value, which increments by 1 per accept and wraps from 2^SEQ_W-1 to 0.
REQ-030 flush SHALL take priority over all other events: next state EMPTY, any same-cycle accept discarded, sequence counter not advanced for the discarded entry.
REQ-031 out_ctrl SHALL be all zeros whenever out_valid = 0 (bubble = NOP control); out_ops/out_addr may hold stale values.
REQ-032 bubble_cnt SHALL increment by 1 each cycle with out_valid = 0 and out_ready = 1, saturating at 2^CNT_W-1; unaffected by flush.

Reset
REQ-033 While reset = 0: state EMPTY, in_ready 0, out_valid 0, occupancy 0, all data/addr/ctrl/skid registers 0, sequence counter 0, bubble_cnt 0.
REQ-034 First cycle after reset release, in_ready SHALL be 1; reset asserted mid-transfer SHALL discard all held entries immediately.

Structure
REQ-035 State encoding enum and default parameter constants SHALL live in the shared package pipe_pkg.
REQ-036 The saturating counter SHALL be a separate sub-module sat_counter (parameter width, inputs inc/clear).
REQ-037 No latches; all registers use non-blocking assignment in a single clocked process per register group.

Verification
REQ-038 Reset then single entry in_ops word0=0x11111111, out_ready=1 -> out_valid next cycle, out_ops word0=0x11111111, out_seq=0.
REQ-039 Back-to-back entries A,B,C with out_ready held 0 -> occupancy 2, in_ready 0 after B; C held off; release out_ready -> A,B,C delivered in order, seq 0,1,2.
REQ-040 Stage FULL, flush=1 with in_valid=1 -> next cycle out_valid 0, out_ctrl 0, occupancy 0, next accepted entry gets seq 2 (not 3).
REQ-041 255 accepts then 2 more with SEQ_W=8 -> tags 254, 255, 0.
REQ-042 Idle with out_ready=1 for 2^CNT_W+5 cycles, CNT_W=4 -> bubble_cnt saturates at 15.
REQ-043 reset driven low while FULL, mid-cycle -> outputs zero immediately without clock edge; resumes accepting one cycle after release.
